// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: requester/response bundle between the FFT sequencers and the shared-adder arbiter.
interface adder_arbiter_if;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic signed [11:0] req0_a0, req0_b0, req0_a1, req0_b1;
  logic signed [11:0] req1_a0, req1_b0, req1_a1, req1_b1;
  logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic signed [11:0] rsp_out0, rsp_out1;
  logic [1:0] in_flight;
  modport slave (
    input  req0_valid, req1_valid, req0_a0, req0_b0, req0_a1, req0_b1,
           req1_a0, req1_b0, req1_a1, req1_b1, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_out0, rsp_out1, in_flight
  );
  modport master (
    output req0_valid, req1_valid, req0_a0, req0_b0, req0_a1, req0_b1,
           req1_a0, req1_b0, req1_a1, req1_b1, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_out0, rsp_out1, in_flight
  );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: grants a shared two-stage halving adder to one of two requesters and
// returns each result to its owner under valid/ready, stalling the pipe on back-pressure.
module adder (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               n_stall,
  input  logic signed [11:0] a0_i,
  input  logic signed [11:0] b0_i,
  input  logic signed [11:0] a1_i,
  input  logic signed [11:0] b1_i,
  output logic signed [11:0] out0_o,
  output logic signed [11:0] out1_o
);
  logic signed [11:0] a0_q, b0_q, a1_q, b1_q, out0_q, out1_q;
  logic [12:0] s0, s1;
  // 13-bit sum keeps the carry, so taking [12:1] is a floor halving that cannot overflow
  assign s0 = {a0_q[11], a0_q} + {b0_q[11], b0_q};
  assign s1 = {a1_q[11], a1_q} + {b1_q[11], b1_q};
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      {a0_q, b0_q, a1_q, b1_q, out0_q, out1_q} <= '0;
    end else if (n_stall) begin
      {a0_q, b0_q, a1_q, b1_q} <= {a0_i, b0_i, a1_i, b1_i};
      out0_q <= s0[12:1];
      out1_q <= s1[12:1];
    end
  assign out0_o = out0_q;
  assign out1_o = out1_q;
endmodule

module adder_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic           clk,
  input logic           n_rst,
  adder_arbiter_if.slave bus
);
  logic v1_q, v1_d, id1_q, id1_d, v2_q, v2_d, id2_q, id2_d, ptr_q, ptr_d;
  logic n_stall, gnt0, gnt1;
  logic signed [11:0] a0, b0, a1, b1, out0, out1;
  always_comb begin
    n_stall = !(v2_q && !(id2_q ? bus.rsp1_ready : bus.rsp0_ready));
    gnt0 = RR_EN ? bus.req0_valid && (!bus.req1_valid || !ptr_q) : bus.req0_valid;
    gnt1 = RR_EN ? bus.req1_valid && (!bus.req0_valid || ptr_q) : bus.req1_valid && !bus.req0_valid;
    a0 = gnt0 ? bus.req0_a0 : gnt1 ? bus.req1_a0 : '0;
    b0 = gnt0 ? bus.req0_b0 : gnt1 ? bus.req1_b0 : '0;
    a1 = gnt0 ? bus.req0_a1 : gnt1 ? bus.req1_a1 : '0;
    b1 = gnt0 ? bus.req0_b1 : gnt1 ? bus.req1_b1 : '0;
    v1_d = n_stall ? gnt0 || gnt1 : v1_q;
    id1_d = n_stall ? gnt1 : id1_q;
    v2_d = n_stall ? v1_q : v2_q;
    id2_d = n_stall ? id1_q : id2_q;
    // pointer moves to the requester that lost (or was absent) on every accepted grant
    ptr_d = (n_stall && (gnt0 || gnt1)) ? gnt0 : ptr_q;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      {v1_q, id1_q, v2_q, id2_q, ptr_q} <= '0;
    end else begin
      {v1_q, id1_q, v2_q, id2_q, ptr_q} <= {v1_d, id1_d, v2_d, id2_d, ptr_d};
    end
  adder u_adder (
    .clk    (clk),
    .n_rst  (n_rst),
    .n_stall(n_stall),
    .a0_i   (a0),
    .b0_i   (b0),
    .a1_i   (a1),
    .b1_i   (b1),
    .out0_o (out0),
    .out1_o (out1)
  );
  assign bus.req0_ready = n_rst && n_stall && gnt0;
  assign bus.req1_ready = n_rst && n_stall && gnt1;
  assign bus.rsp0_valid = v2_q && !id2_q;
  assign bus.rsp1_valid = v2_q && id2_q;
  assign bus.rsp_out0 = out0;
  assign bus.rsp_out1 = out1;
  assign bus.in_flight = {1'b0, v1_q} + {1'b0, v2_q};
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for the two-requester adder arbiter
// (round-robin instance plus a fixed-priority instance).
module tb_adder_arbiter;
  typedef struct packed { logic signed [11:0] a0, b0, a1, b1; } op_t;
  typedef struct packed { logic id; logic signed [11:0] o0, o1; } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  exp_t ex;
  logic acc0, acc1, got, miss, obs_id, rdy0, rdy1, rv0, rv1;
  logic signed [11:0] obs0, obs1;
  logic [1:0] inf;
  op_t z = '0;

  adder_arbiter_if bus ();
  adder_arbiter_if bus_fp ();
  adder_arbiter dut (.clk(clk), .n_rst(n_rst), .bus(bus.slave));
  adder_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .n_rst(n_rst), .bus(bus_fp.slave));

  always #5 clk = ~clk;

  function automatic logic signed [11:0] half(input logic signed [11:0] a, input logic signed [11:0] b);
    int s;
    s = int'(a) + int'(b);
    return 12'(s >>> 1);
  endfunction

  function automatic exp_t mk(input logic id, input op_t op);
    exp_t e;
    e.id = id;
    e.o0 = half(op.a0, op.b0);
    e.o1 = half(op.a1, op.b1);
    return e;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.a0 = 12'($urandom); o.b0 = 12'($urandom);
    o.a1 = 12'($urandom); o.b1 = 12'($urandom);
    return o;
  endfunction

  // drive on negedge, sample just before the next posedge, keep the scoreboard in step
  task automatic cycle(input logic v0, input logic v1, input op_t op0, input op_t op1,
                       input logic r0, input logic r1);
    @(negedge clk);
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    {bus.req0_a0, bus.req0_b0, bus.req0_a1, bus.req0_b1} = op0;
    {bus.req1_a0, bus.req1_b0, bus.req1_a1, bus.req1_b1} = op1;
    bus.rsp0_ready = r0;
    bus.rsp1_ready = r1;
    #4;
    rdy0 = bus.req0_ready; rdy1 = bus.req1_ready;
    acc0 = v0 && rdy0; acc1 = v1 && rdy1;
    rv0 = bus.rsp0_valid; rv1 = bus.rsp1_valid;
    obs0 = bus.rsp_out0; obs1 = bus.rsp_out1;
    inf = bus.in_flight;
    obs_id = rv1;
    got = (rv0 && r0) || (rv1 && r1);
    miss = 1'b0;
    ex = '0;
    if (got) begin
      if (sb.size() == 0) miss = 1'b1;
      else ex = sb.pop_front();
    end
    if (acc0) sb.push_back(mk(1'b0, op0));
    if (acc1) sb.push_back(mk(1'b1, op1));
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    {bus.req0_a0, bus.req0_b0, bus.req0_a1, bus.req0_b1} = '0;
    {bus.req1_a0, bus.req1_b0, bus.req1_a1, bus.req1_b1} = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus_fp.req0_valid = 1'b0; bus_fp.req1_valid = 1'b0;
    {bus_fp.req0_a0, bus_fp.req0_b0, bus_fp.req0_a1, bus_fp.req0_b1} = '0;
    {bus_fp.req1_a0, bus_fp.req1_b0, bus_fp.req1_a1, bus_fp.req1_b1} = '0;
    bus_fp.rsp0_ready = 1'b1; bus_fp.rsp1_ready = 1'b1;
    #3;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", {bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
      failures++; $display("FAIL reset_rsp_valid got=%b exp=00", {bus.rsp0_valid, bus.rsp1_valid});
    end
    checks++;
    if ({bus.rsp_out0, bus.rsp_out1} !== 24'd0) begin
      failures++; $display("FAIL reset_rsp_out got=%0d/%0d exp=0/0", bus.rsp_out0, bus.rsp_out1);
    end
    checks++;
    if (bus.in_flight !== 2'd0) begin
      failures++; $display("FAIL reset_in_flight got=%0d exp=0", bus.in_flight);
    end
    @(negedge clk);
    n_rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  task automatic test_single();
    op_t op;
    op.a0 = 12'sd100; op.b0 = 12'sd51; op.a1 = -12'sd3; op.b1 = 12'sd0;
    cycle(1'b1, 1'b0, op, z, 1'b1, 1'b1);
    checks++;
    if (acc0 !== 1'b1) begin failures++; $display("FAIL single_accept got=%b exp=1", acc0); end
    cycle(1'b0, 1'b0, z, z, 1'b1, 1'b1);
    checks++;
    if ({inf, rv0} !== 3'b010) begin failures++; $display("FAIL single_t1 got=inf%0d/v%b exp=inf1/v0", inf, rv0); end
    cycle(1'b0, 1'b0, z, z, 1'b1, 1'b1);
    checks++;
    if ({inf, rv0, rv1} !== 4'b0110) begin
      failures++; $display("FAIL single_t2 got=inf%0d/v%b%b exp=inf1/v10", inf, rv0, rv1);
    end
    checks++;
    if (!got || miss || obs0 !== 12'sd75 || obs1 !== -12'sd2 || {obs_id, obs0, obs1} !== ex) begin
      failures++; $display("FAIL single_rsp got=%0d/%0d exp=75/-2 miss=%b", obs0, obs1, miss);
    end
    cycle(1'b0, 1'b0, z, z, 1'b1, 1'b1);
    checks++;
    if (inf !== 2'd0) begin failures++; $display("FAIL single_t3 got=%0d exp=0", inf); end
  endtask

  task automatic test_extremes();
    op_t op;
    op.a0 = 12'sd2047; op.b0 = 12'sd2047; op.a1 = -12'sd2048; op.b1 = -12'sd2048;
    cycle(1'b0, 1'b1, z, op, 1'b1, 1'b1);
    checks++;
    if (acc1 !== 1'b1) begin failures++; $display("FAIL ext_accept got=%b exp=1", acc1); end
    cycle(1'b0, 1'b0, z, z, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, z, z, 1'b1, 1'b1);
    checks++;
    if ({rv0, rv1} !== 2'b01) begin failures++; $display("FAIL ext_valid got=%b%b exp=01", rv0, rv1); end
    checks++;
    if (!got || miss || obs0 !== 12'sd2047 || obs1 !== -12'sd2048 || {obs_id, obs0, obs1} !== ex) begin
      failures++; $display("FAIL ext_rsp got=%0d/%0d exp=2047/-2048 miss=%b", obs0, obs1, miss);
    end
  endtask

  task automatic test_contention();
    int nrsp = 0;
    logic exp_id = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(i < 6, i < 6, rnd_op(), rnd_op(), 1'b1, 1'b1);
      if (i < 6) begin
        checks++;
        if ({acc0, acc1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          failures++; $display("FAIL rr_grant cyc=%0d got=%b%b exp=%b", i, acc0, acc1, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      if (got) begin
        checks++;
        if (miss || {obs_id, obs0, obs1} !== ex || obs_id !== exp_id) begin
          failures++; $display("FAIL rr_rsp cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", i, obs_id, obs0, obs1, ex.id, ex.o0, ex.o1);
        end
        nrsp++;
        exp_id = ~exp_id;
      end
    end
    checks++;
    if (nrsp !== 6 || sb.size() != 0) begin
      failures++; $display("FAIL rr_count got=%0d left=%0d exp=6/0", nrsp, sb.size());
    end
  endtask

  task automatic test_fixed();
    int c0 = 0;
    int c1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_fp.req0_valid = 1'b1; bus_fp.req1_valid = 1'b1;
      #4;
      c0 += int'(bus_fp.req0_ready);
      c1 += int'(bus_fp.req1_ready);
    end
    @(negedge clk);
    bus_fp.req0_valid = 1'b0; bus_fp.req1_valid = 1'b0;
    checks++;
    if (c0 !== 6 || c1 !== 0) begin failures++; $display("FAIL fixed_prio got=%0d/%0d exp=6/0", c0, c1); end
  endtask

  task automatic test_back_pressure();
    op_t bp [4];
    int sent = 0;
    int nrsp = 0;
    logic signed [11:0] h0 = '0;
    logic signed [11:0] h1 = '0;
    for (int i = 0; i < 4; i++) bp[i] = rnd_op();
    for (int c = 0; c < 12; c++) begin
      cycle(sent < 4, 1'b0, bp[sent % 4], z, !(c >= 2 && c <= 4), 1'b1);
      if (c >= 2 && c <= 4) begin
        if (c == 2) begin h0 = obs0; h1 = obs1; end
        checks++;
        if ({rv0, rdy0, inf} !== 4'b1010 || obs0 !== h0 || obs1 !== h1) begin
          failures++; $display("FAIL bp_hold cyc=%0d got=v%b/r%b/inf%0d/%0d/%0d exp=v1/r0/inf2/%0d/%0d", c, rv0, rdy0, inf, obs0, obs1, h0, h1);
        end
      end
      if (acc0) sent++;
      if (got) begin
        checks++;
        if (miss || {obs_id, obs0, obs1} !== ex) begin
          failures++; $display("FAIL bp_rsp cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", c, obs_id, obs0, obs1, ex.id, ex.o0, ex.o1);
        end
        nrsp++;
      end
    end
    checks++;
    if (nrsp !== 4 || sent !== 4 || sb.size() != 0) begin
      failures++; $display("FAIL bp_count got=%0d/%0d left=%0d exp=4/4/0", nrsp, sent, sb.size());
    end
  endtask

  task automatic test_mixed_stall();
    op_t m0 = rnd_op();
    op_t m1 = rnd_op();
    cycle(1'b0, 1'b1, z, m1, 1'b1, 1'b0);
    checks++;
    if (acc1 !== 1'b1) begin failures++; $display("FAIL mix_accept got=%b exp=1", acc1); end
    cycle(1'b0, 1'b0, z, z, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, m0, z, 1'b1, 1'b0);
      checks++;
      if ({rv1, rdy0} !== 2'b10) begin failures++; $display("FAIL mix_stall cyc=%0d got=v%b/r%b exp=v1/r0", i, rv1, rdy0); end
    end
    cycle(1'b1, 1'b0, m0, z, 1'b1, 1'b1);
    checks++;
    if (rdy0 !== 1'b1) begin failures++; $display("FAIL mix_release got=%b exp=1", rdy0); end
    checks++;
    if (!got || miss || {obs_id, obs0, obs1} !== ex) begin
      failures++; $display("FAIL mix_rsp1 got=%b/%0d/%0d exp=%b/%0d/%0d", obs_id, obs0, obs1, ex.id, ex.o0, ex.o1);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, z, z, 1'b1, 1'b1);
      if (got) begin
        checks++;
        if (miss || {obs_id, obs0, obs1} !== ex) begin
          failures++; $display("FAIL mix_rsp0 got=%b/%0d/%0d exp=%b/%0d/%0d", obs_id, obs0, obs1, ex.id, ex.o0, ex.o1);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL mix_drain left=%0d exp=0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int nrsp = 0;
    cycle(1'b0, 1'b1, z, rnd_op(), 1'b1, 1'b1);
    cycle(1'b1, 1'b0, rnd_op(), z, 1'b1, 1'b1);
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready} !== 4'b0000) begin
      failures++; $display("FAIL rstmid_flags got=%b exp=0000", {bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if ({bus.rsp_out0, bus.rsp_out1} !== 24'd0 || bus.in_flight !== 2'd0) begin
      failures++; $display("FAIL rstmid_data got=%0d/%0d/inf%0d exp=0/0/inf0", bus.rsp_out0, bus.rsp_out1, bus.in_flight);
    end
    #1;
    n_rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    sb.delete();
    cycle(1'b1, 1'b1, rnd_op(), rnd_op(), 1'b1, 1'b1);
    checks++;
    if ({acc0, acc1} !== 2'b10) begin failures++; $display("FAIL rstmid_ptr got=%b%b exp=10", acc0, acc1); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, z, z, 1'b1, 1'b1);
      if (got) begin
        checks++;
        if (miss || {obs_id, obs0, obs1} !== ex) begin
          failures++; $display("FAIL rstmid_rsp got=%b/%0d/%0d exp=%b/%0d/%0d miss=%b", obs_id, obs0, obs1, ex.id, ex.o0, ex.o1, miss);
        end
        nrsp++;
      end
    end
    checks++;
    if (nrsp !== 1) begin failures++; $display("FAIL rstmid_count got=%0d exp=1", nrsp); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_contention();
    test_fixed();
    test_back_pressure();
    test_mixed_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
